// File: rtl/uart_pkg.sv
// Shared UART-Tx definitions: framer state encoding, parity-type codes, frame sizes.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  localparam logic [1:0] PARITY_NONE0 = 2'b00;
  localparam logic [1:0] PARITY_ODD   = 2'b01;
  localparam logic [1:0] PARITY_EVEN  = 2'b10;
  localparam logic [1:0] PARITY_NONE3 = 2'b11;

  localparam int FRAME_MIN_BITS = 9;
  localparam int FRAME_MAX_BITS = 12;

  localparam logic [2:0] LAST_BIT_7 = 3'd6;
  localparam logic [2:0] LAST_BIT_8 = 3'd7;

  function automatic logic parity_enabled(input logic [1:0] ptype);
    return (ptype == PARITY_ODD) || (ptype == PARITY_EVEN);
  endfunction

endpackage

// File: rtl/uart_tx_piso.sv
// UART transmit framer: latches byte + external parity, shifts start/data/parity/stop out LSB first.
// All outputs registered; line only moves on BaudTick edges; Send is ignored while Busy.
module uart_tx_piso
  import uart_pkg::*;
(
  input  logic       Clock,
  input  logic       ResetN,
  input  logic       BaudTick,
  input  logic       Send,
  input  logic [7:0] DataIn,
  input  logic       ParityOut,
  input  logic [1:0] ParityType,
  input  logic       DataLength,
  input  logic       StopBits,
  output logic       DataOut,
  output logic       Busy,
  output logic       Done
);

  tx_state_t  state;
  logic [7:0] shift_reg;
  logic [2:0] data_cnt;
  logic       stop_cnt;
  logic       par_bit;
  logic [1:0] par_type;
  logic       len8;
  logic       stop2;

  logic [2:0] last_bit;
  assign last_bit = len8 ? LAST_BIT_8 : LAST_BIT_7;

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state     <= ST_IDLE;
      shift_reg <= '0;
      data_cnt  <= '0;
      stop_cnt  <= 1'b0;
      par_bit   <= 1'b0;
      par_type  <= PARITY_NONE0;
      len8      <= 1'b0;
      stop2     <= 1'b0;
      DataOut   <= 1'b1;
      Busy      <= 1'b0;
      Done      <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        ST_IDLE: begin
          DataOut <= 1'b1;
          // The Done cycle still counts as busy; acceptance resumes one cycle later.
          if (Done) begin
            Busy <= 1'b0;
          end else if (Send) begin
            shift_reg <= DataIn;
            par_bit   <= ParityOut;
            par_type  <= ParityType;
            len8      <= DataLength;
            stop2     <= StopBits;
            Busy      <= 1'b1;
            state     <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (BaudTick) begin
            DataOut <= 1'b0;
            state   <= ST_START;
          end
        end

        ST_START: begin
          if (BaudTick) begin
            DataOut  <= shift_reg[0];
            data_cnt <= '0;
            state    <= ST_DATA;
          end
        end

        ST_DATA: begin
          if (BaudTick) begin
            shift_reg <= shift_reg >> 1;
            data_cnt  <= data_cnt + 3'd1;
            if (data_cnt == last_bit) begin
              if (parity_enabled(par_type)) begin
                DataOut <= par_bit;
                state   <= ST_PARITY;
              end else begin
                DataOut  <= 1'b1;
                stop_cnt <= 1'b0;
                state    <= ST_STOP;
              end
            end else begin
              DataOut <= shift_reg[1];
            end
          end
        end

        ST_PARITY: begin
          if (BaudTick) begin
            DataOut  <= 1'b1;
            stop_cnt <= 1'b0;
            state    <= ST_STOP;
          end
        end

        ST_STOP: begin
          if (BaudTick) begin
            if (stop2 && !stop_cnt) begin
              stop_cnt <= 1'b1;
            end else begin
              Done  <= 1'b1;
              state <= ST_IDLE;
            end
            DataOut <= 1'b1;
          end
        end

        default: begin
          DataOut <= 1'b1;
          Busy    <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx_piso.md
# uart_tx_piso

Transmit-side framer/serializer of the UART-Tx path. Latches a data byte plus the parity bit produced by the `Parity` block. Shifts out a complete asynchronous frame on one serial line:

- start bit
- 7 or 8 data bits, LSB first
- optional parity bit
- 1 or 2 stop bits

It sits directly downstream of `Parity` and is paced by a one-cycle baud tick from the baud generator.

## Interface

Parameters:
- None. Frame format is selected at run time.

Ports:
- `Clock`  in  1  system clock; all state changes on rising edge.
- `ResetN`  in  1  reset, asynchronous and active-low.
- `BaudTick`  in  1  one-`Clock`-wide pulse per bit period.
- `Send`  in  1  request to transmit; level-sampled.
- `DataIn`  in  8  byte to send; the same bus feeds `Parity`.
- `ParityOut`  in  1  parity bit from `Parity` for the current `DataIn`/`ParityType`.
- `ParityType`  in  2  00 none, 01 odd, 10 even, 11 none.
- `DataLength`  in  1  0 = 7 data bits (`DataIn[6:0]`), 1 = 8 data bits.
- `StopBits`  in  1  0 = one stop bit, 1 = two stop bits.
- `DataOut`  out  1  serial line; idle high.
- `Busy`  out  1  high from acceptance until frame end.
- `Done`  out  1  one-cycle pulse at frame end.

## Operation

States: IDLE, WAIT, START, DATA, PARITY, STOP.

- **Reset** (asynchronous, immediate, also mid-frame):
  - `DataOut` = 1, `Busy` = 0, `Done` = 0.
  - State = IDLE; counters and shift register cleared.
- **IDLE**: `DataOut` = 1. On `Send` = 1:
  - Latch `DataIn`, `ParityOut`, `ParityType`, `DataLength`, `StopBits` into frame registers.
  - Go to WAIT.
  - After acceptance, input changes do not affect the frame in flight.
- **WAIT**: `DataOut` = 1. On `BaudTick`, go to START.
- **START**: `DataOut` = 0. On `BaudTick`:
  - Go to DATA.
  - Bit counter = 0.
- **DATA**: `DataOut` = shift register bit 0. On `BaudTick`:
  - Shift right and increment the counter.
  - After bit index 6 (7-bit mode) or 7 (8-bit mode):
    - Go to PARITY if the latched `ParityType` is 01 or 10.
    - Otherwise go to STOP.
- **PARITY**: `DataOut` = latched `ParityOut`, used as delivered with no recomputation. On `BaudTick`, go to STOP.
- **STOP**: `DataOut` = 1. Lasts 1 or 2 bit periods per the latched `StopBits`. On the final `BaudTick`:
  - `Done` = 1 for that cycle.
  - Return to IDLE.
- **Parity for 7-bit frames**: `Parity` covers all 8 bits. Top level ties `DataIn[7]` = 0 when `DataLength` = 0.
- **`Send` while `Busy`**: ignored; not queued.
- **`Send` high in the `Done` cycle**: not accepted that cycle. Accepted the next cycle if still high, giving back-to-back frames with one WAIT gap.
- **`Send` held high**: one frame per acceptance, repeating.
- **`BaudTick` in the same cycle as acceptance**: does not advance; the frame waits for the next tick.
- **Frame length** in bit periods: 1 + (7|8) + (0|1) + (1|2). Range 9..12.

## Timing

- `Busy` rises the cycle after `Send` is sampled in IDLE.
- `Busy` falls the cycle after `Done`.
- `DataOut` changes only on the `Clock` edge where `BaudTick` = 1, except at reset.
- Each bit holds exactly one `BaudTick` interval.
- `DataOut`, `Busy` and `Done` are all registered; no combinational input-to-output path.
- Latency from acceptance to the start-bit edge: up to one `BaudTick` interval plus 1 cycle.

## Structure

- Shared package `uart_pkg`:
  - State enum.
  - `ParityType` encodings: `PARITY_NONE0`, `PARITY_ODD`, `PARITY_EVEN`, `PARITY_NONE3`.
  - Frame-length constants.
- Single module, no sub-module. Contains:
  - the FSM,
  - a 3-bit data counter,
  - a 1-bit stop counter,
  - an 8-bit shift register.
- `Parity` is instanced alongside it at the UART-Tx top, sharing `DataIn` and `ParityType`.

## Test plan

- **Reset mid-frame**: assert `ResetN` = 0 during DATA → `DataOut` = 1, `Busy` = 0 immediately. After release, a new `Send` produces a full, correct frame.
- **0xA5, 8 bits, even parity (`ParityOut` = 0), 1 stop** → line sequence 0,1,0,1,0,0,1,0,1,0,1 over 11 ticks. `Done` pulses on the 11th tick.
- **0x0F, 8 bits, odd parity (`ParityOut` = 1), 2 stop** → 0,1,1,1,1,0,0,0,0,1,1,1 (12 ticks). `Busy` is high throughout.
- **0x55, 7 bits, `ParityType` = 11, 1 stop** → 0,1,0,1,0,1,0,1,1 (9 ticks). No parity bit.
- **`Send` held high, `DataIn` changed mid-frame** → first frame unaffected by the change. The second frame starts from WAIT right after `Done` and carries the new byte.
- **`BaudTick` coincident with acceptance** → no advance on that tick. The start bit appears on the following tick.
